// File: rtl/pipe_ctrl.sv
// pipe_ctrl: elastic chain of STAGES pipeline register slots carrying a
// payload plus destination-register tag, with valid/ready backpressure,
// per-slot flush, RAW hazard detection and operand forwarding.
//
// Build option: define PIPE_CTRL_FWD_EN to enable forwarding with
// load-use-only stalling. Without it the block is interlock-only: any
// in-flight writer of a source register stalls the incoming instruction
// and the fwd* outputs are tied to zero.
module pipe_ctrl #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int REGW   = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [REGW-1:0]           in_rd,
  input  logic                      in_wen,
  input  logic                      in_load,
  input  logic [REGW-1:0]           in_rs1,
  input  logic [REGW-1:0]           in_rs2,
  input  logic [STAGES-1:0]         flush_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [REGW-1:0]           out_rd,
  output logic                      out_wen,
  output logic                      fwd1_hit,
  output logic                      fwd2_hit,
  output logic [WIDTH-1:0]          fwd1_data,
  output logic [WIDTH-1:0]          fwd2_data,
  output logic [$clog2(STAGES)-1:0] fwd1_stage,
  output logic [$clog2(STAGES)-1:0] fwd2_stage
);

  localparam int SW = $clog2(STAGES);

  // Slot state. Only the valid bits are reset; the payload fields are
  // meaningless while their slot is empty.
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] valid_next;
  logic [WIDTH-1:0]  data_reg [STAGES];
  logic [REGW-1:0]   rd_reg   [STAGES];
  logic [STAGES-1:0] wen_reg;
  logic [STAGES-1:0] load_reg;

  // rdy[k]: slot k can take a new occupant at the next edge.
  logic [STAGES-1:0] rdy;

  // Per-slot source-register matches against the waiting instruction.
  logic [STAGES-1:0] match1;
  logic [STAGES-1:0] match2;

  logic haz1;
  logic haz2;
  logic hazard;

  // Ready chain from the output back to slot 0, so an empty slot fills
  // even while an older slot is stalled (bubbles compress).
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !valid_reg[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      rdy[k] = !valid_reg[k] || rdy[k+1];
    end
  end

  // Match detection per slot; register 0 is hard-wired and never matches.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_match
      assign match1[gi] = valid_reg[gi] && wen_reg[gi] &&
                          (rd_reg[gi] != '0) && (rd_reg[gi] == in_rs1);
      assign match2[gi] = valid_reg[gi] && wen_reg[gi] &&
                          (rd_reg[gi] != '0) && (rd_reg[gi] == in_rs2);
    end
  endgenerate

`ifdef PIPE_CTRL_FWD_EN
  logic          sel1_found;
  logic          sel2_found;
  logic [SW-1:0] sel1_idx;
  logic [SW-1:0] sel2_idx;
  logic [WIDTH-1:0] sel1_data;
  logic [WIDTH-1:0] sel2_data;

  // Youngest-match select: scan oldest to youngest so the lowest index wins.
  always_comb begin
    sel1_found = 1'b0;
    sel2_found = 1'b0;
    sel1_idx   = '0;
    sel2_idx   = '0;
    sel1_data  = '0;
    sel2_data  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (match1[k]) begin
        sel1_found = 1'b1;
        sel1_idx   = SW'(k);
        sel1_data  = data_reg[k];
      end
      if (match2[k]) begin
        sel2_found = 1'b1;
        sel2_idx   = SW'(k);
        sel2_data  = data_reg[k];
      end
    end
  end

  // A load still in slot 0 has no result yet: that is the only stall case.
  assign haz1 = match1[0] && load_reg[0];
  assign haz2 = match2[0] && load_reg[0];

  assign fwd1_hit   = sel1_found && !haz1;
  assign fwd2_hit   = sel2_found && !haz2;
  assign fwd1_data  = fwd1_hit ? sel1_data : '0;
  assign fwd2_data  = fwd2_hit ? sel2_data : '0;
  assign fwd1_stage = fwd1_hit ? sel1_idx  : '0;
  assign fwd2_stage = fwd2_hit ? sel2_idx  : '0;
`else
  // The load flag only matters when forwarding is available.
  logic unused_load;
  assign unused_load = ^load_reg;

  // Without forwarding any in-flight writer of a source is a hazard.
  assign haz1 = |match1;
  assign haz2 = |match2;

  assign fwd1_hit   = 1'b0;
  assign fwd2_hit   = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
  assign fwd1_stage = '0;
  assign fwd2_stage = '0;
`endif

  assign hazard   = haz1 || haz2;
  assign in_ready = rdy[0] && !hazard;

  // Next occupancy: advance where ready, then apply flush with top priority.
  always_comb begin
    valid_next = valid_reg;
    if (rdy[0]) begin
      // A stalled instruction leaves a bubble behind in slot 0.
      valid_next[0] = in_valid && in_ready;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        valid_next[k] = valid_reg[k-1];
      end
    end
    valid_next = valid_next & ~flush_mask;
  end

  // Occupancy register; reset drops every in-flight instruction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Payload shift: each slot captures its predecessor whenever it is ready.
  always_ff @(posedge clk) begin
    if (rdy[0]) begin
      data_reg[0] <= in_data;
      rd_reg[0]   <= in_rd;
      wen_reg[0]  <= in_wen;
      load_reg[0] <= in_load;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        data_reg[k] <= data_reg[k-1];
        rd_reg[k]   <= rd_reg[k-1];
        wen_reg[k]  <= wen_reg[k-1];
        load_reg[k] <= load_reg[k-1];
      end
    end
  end

  // Output view of the oldest slot; held while stalled since rdy is low.
  assign out_valid = valid_reg[STAGES-1];
  assign out_data  = data_reg[STAGES-1];
  assign out_rd    = rd_reg[STAGES-1];
  assign out_wen   = wen_reg[STAGES-1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (STAGES=4). Accepted inputs
// are queued at the handshake; the monitor pops and compares every output
// transfer. Hazard/forwarding expectations follow PIPE_CTRL_FWD_EN.
module tb_pipe_ctrl;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int REGW   = 5;
  localparam int SW     = $clog2(STAGES);
`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [REGW-1:0]   in_rd;
  logic              in_wen;
  logic              in_load;
  logic [REGW-1:0]   in_rs1;
  logic [REGW-1:0]   in_rs2;
  logic [STAGES-1:0] flush_mask;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [REGW-1:0]   out_rd;
  logic              out_wen;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [WIDTH-1:0]  fwd1_data;
  logic [WIDTH-1:0]  fwd2_data;
  logic [SW-1:0]     fwd1_stage;
  logic [SW-1:0]     fwd2_stage;

  always #5 clk = ~clk;

  pipe_ctrl #(.WIDTH(WIDTH), .STAGES(STAGES), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rd(in_rd), .in_wen(in_wen), .in_load(in_load),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .flush_mask(flush_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .fwd1_stage(fwd1_stage), .fwd2_stage(fwd2_stage)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [REGW-1:0]  rd;
    logic             wen;
  } item_t;

  item_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every transfer must match the oldest queued instruction.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        item_t e;
        e = exp_q.pop_front();
        $display("txn out data=0x%08h rd=%0d wen=%0b", out_data, out_rd, out_wen);
        check_eq("out_data", 64'(out_data), 64'(e.data));
        check_eq("out_rd",   64'(out_rd),   64'(e.rd));
        check_eq("out_wen",  64'(out_wen),  64'(e.wen));
      end
    end
  end

  task automatic drive_idle();
    in_valid   = 1'b0;
    in_data    = '0;
    in_rd      = '0;
    in_wen     = 1'b0;
    in_load    = 1'b0;
    in_rs1     = '0;
    in_rs2     = '0;
    flush_mask = '0;
  endtask

  // Observe at the falling edge and record an upcoming input handshake.
  task automatic sample();
    item_t it;
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      $display("txn in  data=0x%08h rd=%0d wen=%0b flush0=%0b", in_data, in_rd, in_wen, flush_mask[0]);
      if (!flush_mask[0]) begin
        it.data = in_data;
        it.rd   = in_rd;
        it.wen  = in_wen;
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [REGW-1:0] rd,
                      input logic wen, input logic ld, input int budget);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_rd    = rd;
    in_wen   = wen;
    in_load  = ld;
    for (int c = 0; c < budget; c++) begin
      sample();
      acc = in_ready;
      advance();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check_eq("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drain(input string tag, input int budget);
    drive_idle();
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Writer r enters, then an instruction reading r as rs1 waits behind it.
  task automatic hazard_case(input string tag, input logic [REGW-1:0] r,
                             input logic ld, input logic [WIDTH-1:0] pay);
    logic er, eh, acc;
    logic [SW-1:0] es;
    logic [WIDTH-1:0] ed;
    acc = 1'b0;
    send(pay, r, 1'b1, ld, 4);
    in_valid = 1'b1;
    in_data  = pay + 1;
    in_rd    = '0;
    in_wen   = 1'b0;
    in_load  = 1'b0;
    in_rs1   = r;
    in_rs2   = '0;
    for (int j = 1; j <= STAGES + 2; j++) begin
      // At step j the writer sits in slot j-1.
      if (r == '0) begin
        er = 1'b1; eh = 1'b0; es = '0; ed = '0;
      end else if (!FWD) begin
        er = (j >= STAGES + 1); eh = 1'b0; es = '0; ed = '0;
      end else if (!ld) begin
        er = 1'b1; eh = 1'b1; es = '0; ed = pay;
      end else if (j == 1) begin
        er = 1'b0; eh = 1'b0; es = '0; ed = '0;
      end else begin
        er = 1'b1; eh = 1'b1; es = SW'(1); ed = pay;
      end
      sample();
      check_eq({tag, "_in_ready"},   64'(in_ready),   64'(er));
      check_eq({tag, "_fwd1_hit"},   64'(fwd1_hit),   64'(eh));
      check_eq({tag, "_fwd1_stage"}, 64'(fwd1_stage), 64'(es));
      check_eq({tag, "_fwd1_data"},  64'(fwd1_data),  64'(ed));
      acc = in_ready;
      advance();
      if (acc) break;
    end
    check_eq({tag, "_accepted"}, 64'(acc), 64'(1));
    drain(tag, 20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    in_rs1    = 5'd3;
    in_rs2    = 5'd7;
    #2;
    check_eq("rst_out_valid",  64'(out_valid),  64'(0));
    check_eq("rst_in_ready",   64'(in_ready),   64'(1));
    check_eq("rst_fwd1_hit",   64'(fwd1_hit),   64'(0));
    check_eq("rst_fwd2_hit",   64'(fwd2_hit),   64'(0));
    check_eq("rst_fwd1_stage", 64'(fwd1_stage), 64'(0));
    check_eq("rst_fwd2_data",  64'(fwd2_data),  64'(0));
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    advance();

    // Streaming: 8 back-to-back, first output STAGES edges after first accept.
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_data  = WIDTH'(i + 1);
        in_rd    = REGW'(i + 1);
        in_wen   = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      sample();
      check_eq("stream_out_valid", 64'(out_valid), 64'(i >= STAGES && i < STAGES + 8));
      if (i < 8) check_eq("stream_in_ready", 64'(in_ready), 64'(1));
      advance();
    end
    drain("stream", 20);

    // Backpressure: fill the chain with the output blocked, hold 3 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send(WIDTH'(32'h101 + i), REGW'(i + 1), 1'b0, 1'b0, 4);
    in_valid = 1'b1;
    in_data  = 32'h105;
    in_rd    = 5'd9;
    in_wen   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("bp_in_ready",  64'(in_ready),  64'(0));
      check_eq("bp_out_valid", 64'(out_valid), 64'(1));
      check_eq("bp_out_data",  64'(out_data),  64'(32'h101));
      advance();
    end
    out_ready = 1'b1;
    send(32'h105, 5'd9, 1'b0, 1'b0, 4);
    drain("bp", 20);

    // Hazards: ALU writer, load writer, and register 0.
    hazard_case("alu", 5'd3, 1'b0, 32'h300);
    hazard_case("ld",  5'd5, 1'b1, 32'h500);
    hazard_case("x0",  5'd0, 1'b0, 32'h0AA);

    // Forward priority: rd=7 in slots 1 and 3, youngest wins.
    send(32'h700, 5'd7, 1'b1, 1'b0, 4);
    send(32'h701, 5'd2, 1'b0, 1'b0, 4);
    send(32'h702, 5'd7, 1'b1, 1'b0, 4);
    drive_idle();
    tick();
    in_rs2 = 5'd7;
    sample();
    check_eq("prio_in_ready",   64'(in_ready),   64'(FWD ? 1 : 0));
    check_eq("prio_fwd2_hit",   64'(fwd2_hit),   64'(FWD ? 1 : 0));
    check_eq("prio_fwd2_stage", 64'(fwd2_stage), 64'(FWD ? 1 : 0));
    check_eq("prio_fwd2_data",  64'(fwd2_data),  64'(FWD ? 32'h702 : 0));
    advance();
    drain("prio", 20);

    // Flush slots 0 and 1 on the edge that accepts the 4th item: items 3
    // and 4 vanish, items 1 and 2 continue, leaving a two-cycle gap.
    for (int i = 0; i < 11; i++) begin
      if (i < 6) begin
        in_valid = 1'b1;
        in_data  = WIDTH'(32'hF01 + i);
        in_rd    = REGW'(i + 10);
        in_wen   = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      flush_mask = (i == 3) ? STAGES'(3) : '0;
      sample();
      check_eq("flush_out_valid", 64'(out_valid),
               64'(i == 4 || i == 5 || i == 8 || i == 9));
      if (i < 6) check_eq("flush_in_ready", 64'(in_ready), 64'(1));
      if (i == 3) void'(exp_q.pop_back());
      advance();
    end
    drain("flush", 20);

    // Asynchronous reset mid-stream drops everything immediately.
    for (int i = 0; i < STAGES; i++) send(WIDTH'(32'hA01 + i), REGW'(i + 1), 1'b0, 1'b0, 4);
    check_eq("rst_pre_out_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_mid_in_ready",  64'(in_ready),  64'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    tick();
    check_eq("rst_post_out_valid", 64'(out_valid), 64'(0));
    send(32'hB01, 5'd1, 1'b0, 1'b0, 4);
    send(32'hB02, 5'd2, 1'b0, 1'b0, 4);
    drain("post_rst", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
